booth_ctrl: RTL and testbench
=============================

# booth_ctrl

Sequential controller for the ALU's radix-2 Booth multiplier datapath. It accepts a start request, loads the operands and runs N add/subtract-then-shift iterations. Each iteration's decision is driven by the datapath's Q[0]/Q[-1] bits. It then sequences the high and low product words onto the result bus. The block owns the state register and the iteration counter, and produces every datapath control strobe. The datapath itself (A, Q, M registers and adder) is outside this block.

## Interface
- N, default 8: operand width in bits, meaning the number of Booth iterations; legal range 2..32.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  request a multiply; sampled only in IDLE.
- abort  input  1  synchronous cancel of a running multiply.
- q0  input  1  datapath Q[0].
- qm1  input  1  datapath Q[-1].
- busy  output  1  high in every state except IDLE.
- ld_m  output  1  load multiplicand register M from the operand bus.
- ld_q  output  1  load Q from the operand bus and clear Q[-1].
- clr_a  output  1  clear accumulator A.
- add_en  output  1  write adder result into A.
- sub_sel  output  1  adder performs A − M; when low, A + M; meaningful only with add_en.
- shift_en  output  1  arithmetic right shift of {A,Q,Q[-1]} by one bit.
- out_hi  output  1  drive A onto the result bus.
- out_lo  output  1  drive Q onto the result bus.
- done  output  1  one-cycle completion pulse.
- iter  output  clog2(N)  remaining-iteration counter, for debug and verification.

## Operation
- States: IDLE, INIT, EVAL, SHIFT, OUT_HI, OUT_LO. A 3-bit state register holds them; unused encodings return to IDLE on the next edge.
- IDLE: all strobes low. If start = 1, go to INIT; otherwise stay.
- INIT: ld_m = ld_q = clr_a = 1. Load iter with N−1. Go to EVAL.
- EVAL: the outputs are combinational decodes of {q0, qm1}:
  - 10: add_en = 1, sub_sel = 1.
  - 01: add_en = 1, sub_sel = 0.
  - 00 or 11: no strobe.
  - Always go to SHIFT.
- SHIFT: shift_en = 1.
  - If iter = 0, go to OUT_HI.
  - Otherwise decrement iter and go to EVAL.
- OUT_HI: out_hi = 1; go to OUT_LO.
- OUT_LO: out_lo = 1 and done = 1; go to IDLE.
- Outputs depend only on the state, except add_en and sub_sel in EVAL. Apart from the EVAL decode of add_en/sub_sel, no strobe is asserted outside its listed state.
- abort = 1 in any non-IDLE state sends the block to IDLE on the next edge.
  - The strobes of the current cycle are still driven.
  - done does not pulse, unless the abort cycle is OUT_LO itself; then done is asserted normally.
- start is ignored while busy = 1. A start held high through OUT_LO is accepted on the first IDLE cycle.
- abort in IDLE has no effect. If start and abort are both high in IDLE, start wins and the block goes to INIT.

## Timing
- Reset values: state = IDLE, iter = 0, and every output at 0 (busy, strobes, done).
- Reset is asynchronous. Asserting it mid-operation forces IDLE immediately, with all outputs low. No done pulse follows.
- Latency:
  - start sampled high in IDLE at edge 0.
  - INIT occupies cycle 1.
  - EVAL/SHIFT pairs occupy cycles 2..2N+1.
  - OUT_HI occupies cycle 2N+2.
  - OUT_LO and done occupy cycle 2N+3.
- busy is high for exactly 2N+3 cycles; for N = 8, that is 19 cycles.
- Minimum start-to-start spacing is 2N+4 cycles: one IDLE cycle is mandatory between jobs.
- q0 and qm1 must be stable in EVAL before the edge. They reflect the datapath state after the previous shift, or after INIT for the first iteration.
- iter sequence for N = 8: 7,7 (EVAL,SHIFT), 6,6 and so on down to 0,0. The last SHIFT sees iter = 0 and does not decrement.

## Test plan
- Reset: assert rst mid-cycle during EVAL with N = 8 → busy, shift_en and add_en drop asynchronously; state = IDLE; after release, no done pulse and iter = 0.
- Basic multiply, N = 8, operands 3 × 5, with a behavioral datapath model:
  - Q = 5 gives {q0,qm1} = 10, 01, 10, 01 over the first four EVALs.
  - Required response: sub, add, sub, add, then no strobes.
  - Result words: out_hi with A = 0x00, then out_lo with Q = 0x0F.
  - done pulses at cycle 19 after start.
- Signed case, N = 8, −7 × 6 → exactly 8 shift_en pulses; product 0xFFD6 (A = 0xFF, Q = 0xD6); busy high for 19 cycles.
- Abort: raise abort in the third SHIFT → IDLE next cycle; no done; a new start 1 cycle later completes normally in 19 cycles.
- Handshake: hold start high continuously → two jobs with exactly one IDLE cycle between done and the next INIT. A start pulse in the middle of a job is ignored; the job length is unchanged.
- Boundary, N = 2: {q0,qm1} = 11 on both EVALs → no add_en; busy lasts 7 cycles; iter sequence 1,1,0,0.

Source files
------------

// File: rtl/booth_ctrl.sv
// Control FSM and iteration counter for a radix-2 Booth multiplier datapath.
// Sequences operand load, N evaluate/shift iterations, then high and low result words.
module booth_ctrl #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 q0,
    input  logic                 qm1,
    output logic                 busy,
    output logic                 ld_m,
    output logic                 ld_q,
    output logic                 clr_a,
    output logic                 add_en,
    output logic                 sub_sel,
    output logic                 shift_en,
    output logic                 out_hi,
    output logic                 out_lo,
    output logic                 done,
    output logic [$clog2(N)-1:0] iter
);
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        EVAL   = 3'd2,
        SHIFT  = 3'd3,
        OUT_HI = 3'd4,
        OUT_LO = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        ld_m     = 1'b0;
        ld_q     = 1'b0;
        clr_a    = 1'b0;
        add_en   = 1'b0;
        sub_sel  = 1'b0;
        shift_en = 1'b0;
        out_hi   = 1'b0;
        out_lo   = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                ld_m    = 1'b1;
                ld_q    = 1'b1;
                clr_a   = 1'b1;
                iter_d  = IW'(N - 1);
                state_d = EVAL;
            end
            EVAL: begin
                // {Q[0],Q[-1]}: 10 subtracts M, 01 adds M, 00/11 leave A alone.
                case ({q0, qm1})
                    2'b10: begin
                        add_en  = 1'b1;
                        sub_sel = 1'b1;
                    end
                    2'b01: add_en = 1'b1;
                    default: ;
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (iter_q == '0) begin
                    state_d = OUT_HI;
                end else begin
                    iter_d  = iter_q - IW'(1);
                    state_d = EVAL;
                end
            end
            OUT_HI: begin
                out_hi  = 1'b1;
                state_d = OUT_LO;
            end
            OUT_LO: begin
                out_lo  = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides the successor only; this cycle's strobes stay as decoded.
        if (abort && (state_q != IDLE)) state_d = IDLE;
    end

    assign busy = (state_q != IDLE);
    assign iter = iter_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: an N=8 instance driven by a behavioural A/Q/M datapath,
// and an N=2 instance for the short-operand boundary.
module tb_booth_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // N = 8 instance and its datapath
    logic       start8, abort8;
    logic       q0_8, qm1_8;
    logic       busy8, ld_m8, ld_q8, clr_a8, add_en8, sub_sel8, shift_en8, out_hi8, out_lo8, done8;
    logic [2:0] iter8;
    logic [9:0] vec8;

    // N = 2 instance
    logic       start2, abort2, q0_2, qm1_2;
    logic       busy2, ld_m2, ld_q2, clr_a2, add_en2, sub_sel2, shift_en2, out_hi2, out_lo2, done2;
    logic [0:0] iter2;

    logic [7:0] op_m, op_q;
    logic [7:0] a_r, q_r, m_r;
    logic       qm1_r;

    logic [9:0] exp_q[$];
    int         exp_iter_q[$];

    localparam logic [9:0] V_IDLE  = 10'b0000000000;
    localparam logic [9:0] V_INIT  = 10'b1111000000;
    localparam logic [9:0] V_SHIFT = 10'b1000001000;
    localparam logic [9:0] V_HI    = 10'b1000000100;
    localparam logic [9:0] V_LO    = 10'b1000000011;

    booth_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .q0(q0_8), .qm1(qm1_8),
        .busy(busy8), .ld_m(ld_m8), .ld_q(ld_q8), .clr_a(clr_a8), .add_en(add_en8),
        .sub_sel(sub_sel8), .shift_en(shift_en8), .out_hi(out_hi8), .out_lo(out_lo8),
        .done(done8), .iter(iter8)
    );

    booth_ctrl #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .q0(q0_2), .qm1(qm1_2),
        .busy(busy2), .ld_m(ld_m2), .ld_q(ld_q2), .clr_a(clr_a2), .add_en(add_en2),
        .sub_sel(sub_sel2), .shift_en(shift_en2), .out_hi(out_hi2), .out_lo(out_lo2),
        .done(done2), .iter(iter2)
    );

    assign vec8 = {busy8, ld_m8, ld_q8, clr_a8, add_en8, sub_sel8, shift_en8, out_hi8, out_lo8, done8};
    assign q0_8  = q_r[0];
    assign qm1_8 = qm1_r;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath reacting to the controller's strobes.
    always @(posedge clk) begin
        logic [16:0] t;
        if (ld_m8) m_r <= op_m;
        if (ld_q8) begin
            q_r   <= op_q;
            qm1_r <= 1'b0;
        end
        if (clr_a8) a_r <= 8'h00;
        if (add_en8) a_r <= sub_sel8 ? (a_r - m_r) : (a_r + m_r);
        if (shift_en8) begin
            t = {a_r, q_r, qm1_r};
            t = {t[16], t[16:1]};
            {a_r, q_r, qm1_r} <= t;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected trace comes from the Booth recoding of the multiplier bits:
    // iteration i looks at {q[i], q[i-1]} with q[-1] = 0.
    task automatic run_job(input logic [7:0] m, input logic [7:0] q, input int abort_idx, input int pulse_idx);
        logic [15:0] prod;
        logic [9:0]  ev;
        logic [1:0]  pr;
        int          ei, k, n_busy, exp_busy, pm, pq;
        op_m = m;
        op_q = q;
        pm = int'($signed(m));
        pq = int'($signed(q));
        prod = 16'(pm * pq);
        exp_q.delete();
        exp_iter_q.delete();
        exp_q.push_back(V_INIT);
        exp_iter_q.push_back(-1);
        for (int i = 0; i < 8; i++) begin
            pr = {q[i], (i == 0) ? 1'b0 : q[i-1]};
            exp_q.push_back({4'b1000, (pr == 2'b10 || pr == 2'b01), (pr == 2'b10), 4'b0000});
            exp_iter_q.push_back(7 - i);
            exp_q.push_back(V_SHIFT);
            exp_iter_q.push_back(7 - i);
        end
        exp_q.push_back(V_HI);
        exp_iter_q.push_back(0);
        exp_q.push_back(V_LO);
        exp_iter_q.push_back(0);
        exp_busy = (abort_idx >= 0) ? abort_idx + 1 : 19;

        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        n_busy = 0;
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            ei = exp_iter_q.pop_front();
            abort8 = (k == abort_idx);
            start8 = (k == pulse_idx);
            check_eq("outs", 32'(vec8), 32'(ev));
            if (ei >= 0) check_eq("iter", 32'(iter8), 32'(ei));
            if (out_hi8) check_eq("res_hi", 32'(a_r), 32'(prod[15:8]));
            if (out_lo8) check_eq("res_lo", 32'(q_r), 32'(prod[7:0]));
            if (busy8) n_busy++;
            @(negedge clk);
            abort8 = 1'b0;
            start8 = 1'b0;
            if (k == abort_idx) begin
                exp_q.delete();
                exp_iter_q.delete();
            end
            k++;
        end
        check_eq("busy_len", 32'(n_busy), 32'(exp_busy));
        check_eq("idle_after", 32'(vec8), 32'(V_IDLE));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        start8 = 0; abort8 = 0; start2 = 0; abort2 = 0;
        q0_2 = 1'b1; qm1_2 = 1'b1;
        op_m = 0; op_q = 0;
        rst = 1'b1;
        #1;
        check_eq("rst_outs", 32'(vec8), 32'(V_IDLE));
        check_eq("rst_iter", 32'(iter8), 0);
        check_eq("rst_busy2", 32'(busy2), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // abort in IDLE does nothing
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        check_eq("idle_abort", 32'(vec8), 32'(V_IDLE));

        run_job(8'd3, 8'd5, -1, -1);
        run_job(8'hF9, 8'd6, -1, -1);
        run_job(8'h5A, 8'h93, 6, -1);
        run_job(8'h21, 8'h44, -1, -1);
        run_job(8'h7F, 8'h80, -1, 7);
        run_job(8'h11, 8'h0C, 18, -1);
        for (int r = 0; r < 8; r++)
            run_job(8'($urandom), 8'($urandom), -1, (r % 2 == 0) ? int'($urandom_range(1, 17)) : -1);

        // start and abort together in IDLE: start wins
        abort8 = 1'b1;
        run_job(8'h09, 8'h0B, -1, -1);

        // start held high: two jobs with a single IDLE cycle between them
        op_m = 8'h13;
        op_q = 8'h2D;
        start8 = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            if (c == 20) start8 = 1'b0;
            check_eq("hold_busy", 32'(busy8), 32'(!(c == 19 || c == 39)));
            check_eq("hold_ldm", 32'(ld_m8), 32'(c == 0 || c == 20));
            check_eq("hold_done", 32'(done8), 32'(c == 18 || c == 38));
            @(negedge clk);
        end

        // asynchronous reset during an adding EVAL of 3 x 5
        op_m = 8'd3;
        op_q = 8'd5;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_add", 32'(add_en8), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_outs", 32'(vec8), 32'(V_IDLE));
        check_eq("async_iter", 32'(iter8), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 22; c++) begin
            check_eq("post_rst_done", 32'(done8), 0);
            check_eq("post_rst_busy", 32'(busy8), 0);
            @(negedge clk);
        end
        check_eq("post_rst_iter", 32'(iter8), 0);

        // N = 2 with {q0,qm1} = 11 throughout
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check_eq("n2_busy", 32'(busy2), 32'(c < 7));
            check_eq("n2_add", 32'(add_en2), 0);
            check_eq("n2_shift", 32'(shift_en2), 32'(c == 2 || c == 4));
            check_eq("n2_done", 32'(done2), 32'(c == 6));
            if (c >= 1 && c <= 4) check_eq("n2_iter", 32'(iter2), 32'((c <= 2) ? 1 : 0));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
